// File: rtl/range_stats_pkg.sv
// Shared types and default widths for the range/stats measurement engine.
package range_stats_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } rs_state_t;

    localparam int RS_WIDTH     = 16;
    localparam int RS_CNT_WIDTH = 16;
endpackage

// File: rtl/range_stats_finder_if.sv
// Sample stream in, measurement results out. Master drives samples, slave is the engine.
interface range_stats_finder_if
    import range_stats_pkg::*;
#(
    parameter int WIDTH     = RS_WIDTH,
    parameter int CNT_WIDTH = RS_CNT_WIDTH
);
    logic [WIDTH-1:0]           data_in;
    logic                       go;
    logic                       finish;
    logic [WIDTH-1:0]           range;
    logic [WIDTH-1:0]           min_out;
    logic [WIDTH-1:0]           max_out;
    logic [CNT_WIDTH-1:0]       count;
    logic [WIDTH+CNT_WIDTH-1:0] sum;
    logic                       done;
    logic                       error;

    modport master (
        output data_in, go, finish,
        input  range, min_out, max_out, count, sum, done, error
    );
    modport slave (
        input  data_in, go, finish,
        output range, min_out, max_out, count, sum, done, error
    );
endinterface

// File: rtl/range_stats_datapath.sv
// Working min/max/count(/sum) registers and committed result registers.
// Running sum exists only when RANGE_STATS_FINDER_SUM_EN is defined.
module range_stats_datapath
    import range_stats_pkg::*;
#(
    parameter int WIDTH     = RS_WIDTH,
    parameter int SIGNED    = 0,
    parameter int CNT_WIDTH = RS_CNT_WIDTH
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       load_i,
    input  logic                       update_i,
    input  logic                       commit_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           range_o,
    output logic [WIDTH-1:0]           min_o,
    output logic [WIDTH-1:0]           max_o,
    output logic [CNT_WIDTH-1:0]       count_o,
    output logic [WIDTH+CNT_WIDTH-1:0] sum_o
);
    function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    logic [WIDTH-1:0]     wmin_q, wmax_q, min_d, max_d;
    logic [WIDTH-1:0]     range_q, omin_q, omax_q;
    logic [CNT_WIDTH-1:0] wcnt_q, cnt_d, ocnt_q;

    // Next working values include the current sample; commit uses them too.
    always_comb begin
        min_d = lt(data_i, wmin_q) ? data_i : wmin_q;
        max_d = lt(wmax_q, data_i) ? data_i : wmax_q;
        cnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wmin_q  <= '0;
            wmax_q  <= '0;
            wcnt_q  <= '0;
            range_q <= '0;
            omin_q  <= '0;
            omax_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            if (load_i) begin
                wmin_q <= data_i;
                wmax_q <= data_i;
                wcnt_q <= CNT_WIDTH'(1);
            end else if (update_i || commit_i) begin
                wmin_q <= min_d;
                wmax_q <= max_d;
                wcnt_q <= cnt_d;
            end
            if (commit_i) begin
                range_q <= max_d - min_d;
                omin_q  <= min_d;
                omax_q  <= max_d;
                ocnt_q  <= cnt_d;
            end
        end
    end

    assign range_o = range_q;
    assign min_o   = omin_q;
    assign max_o   = omax_q;
    assign count_o = ocnt_q;

`ifdef RANGE_STATS_FINDER_SUM_EN
    localparam int SW = WIDTH + CNT_WIDTH;
    logic [SW-1:0] ext, sum_d, wsum_q, osum_q;

    assign ext   = (SIGNED != 0) ? {{CNT_WIDTH{data_i[WIDTH-1]}}, data_i}
                                 : {{CNT_WIDTH{1'b0}}, data_i};
    assign sum_d = wsum_q + ext;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wsum_q <= '0;
            osum_q <= '0;
        end else begin
            if (load_i)                      wsum_q <= ext;
            else if (update_i || commit_i)   wsum_q <= sum_d;
            if (commit_i)                    osum_q <= sum_d;
        end
    end
    assign sum_o = osum_q;
`else
    assign sum_o = '0;
`endif
endmodule

// File: rtl/range_stats_finder.sv
// Framed sample-stream min/max/range/count engine; optional running sum via
// RANGE_STATS_FINDER_SUM_EN. FSM here, arithmetic in range_stats_datapath.
module range_stats_finder
    import range_stats_pkg::*;
#(
    parameter int WIDTH     = RS_WIDTH,
    parameter int SIGNED    = 0,
    parameter int CNT_WIDTH = RS_CNT_WIDTH
) (
    input logic                 clock,
    input logic                 reset,
    range_stats_finder_if.slave bus
);
    rs_state_t state_q, state_d;
    logic      done_q, error_q;
    logic      load, update, commit;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        update  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.go && !bus.finish) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end else if (bus.finish) state_d = ERROR;
                else                     state_d = IDLE;
            end
            ACTIVE: begin
                if (bus.go) state_d = ERROR;
                else if (bus.finish) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else update = 1'b1;
            end
            ERROR: begin
                if (bus.go && !bus.finish) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            error_q <= (state_d == ERROR);
        end
    end

    logic [WIDTH-1:0]           range_w, min_w, max_w;
    logic [CNT_WIDTH-1:0]       count_w;
    logic [WIDTH+CNT_WIDTH-1:0] sum_w;

    range_stats_datapath #(
        .WIDTH     (WIDTH),
        .SIGNED    (SIGNED),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dp (
        .clock_i  (clock),
        .reset_i  (reset),
        .load_i   (load),
        .update_i (update),
        .commit_i (commit),
        .data_i   (bus.data_in),
        .range_o  (range_w),
        .min_o    (min_w),
        .max_o    (max_w),
        .count_o  (count_w),
        .sum_o    (sum_w)
    );

    assign bus.range   = range_w;
    assign bus.min_out = min_w;
    assign bus.max_out = max_w;
    assign bus.count   = count_w;
    assign bus.sum     = sum_w;
    assign bus.done    = done_q;
    assign bus.error   = error_q;
endmodule
